dmem_port_arbiter: RTL
======================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single data-memory port (DMemory, read_enable/read_valid handshake) between two requesters:
//  m0 = Core load/store path, m1 = UART program loader / debug writer.
//  Sits between the bus-side requesters and DMemory.
//  Round-robin arbitration, one outstanding transaction, registered issue to the memory.
// PARAMETERS
//  ADDR_W    32            address width
//  DATA_W    32            data width; write mask is DATA_W/8 bits
//  TIMEOUT   16            read-wait cycles before forced completion (only with DMEM_ARB_TIMEOUT_EN)
// PORTS
//  clk             in   1         clock, rising edge
//  rst             in   1         asynchronous reset, active-high
//  m{0,1}_req      in   1         request; payload stable while req=1 until gnt
//  m{0,1}_we       in   1         1=write, 0=read
//  m{0,1}_addr     in   ADDR_W    byte address
//  m{0,1}_wdata    in   DATA_W    write data
//  m{0,1}_wmask    in   DATA_W/8  byte-lane write mask
//  m{0,1}_gnt      out  1         one-cycle accept pulse; payload captured this cycle
//  m{0,1}_ack      out  1         one-cycle completion pulse (write issued / read data valid)
//  m{0,1}_rdata    out  DATA_W    read data, valid with ack of a read; held until next read completion
//  m{0,1}_err      out  1         one-cycle timeout pulse, coincident with ack
//  s_address       out  ADDR_W    to DMemory address
//  s_write_data    out  DATA_W    to DMemory write_data
//  s_write_mask    out  DATA_W/8  to DMemory write_mask
//  s_write_enable  out  1         one-cycle write strobe
//  s_read_enable   out  1         one-cycle read strobe
//  s_read_data     in   DATA_W    from DMemory read_data
//  s_read_valid    in   1         from DMemory read_valid
//  busy            out  1         state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, last_owner=1, all outputs 0 (rdata 0); in-flight transaction dropped silently.
//  States: IDLE -> ISSUE -> (write) IDLE | (read) RD_WAIT -> IDLE.
//  IDLE: gnt is combinational from req in IDLE only. Only one req -> that master. Both -> master != last_owner.
//   Grant cycle: latch payload + owner, last_owner<=owner, next=ISSUE. No req -> stay.
//  ISSUE (1 cycle): s_* driven from latched regs; s_write_enable=we, s_read_enable=!we.
//   Write: owner ack=1 this cycle, next=IDLE.
//   Read: if s_read_valid this cycle, complete now (zero-latency memory); else next=RD_WAIT.
//  RD_WAIT: s_read_enable=0, s_address held. On s_read_valid: owner rdata<=s_read_data (registered);
//   owner ack=1 the following cycle; next=IDLE.
//  Latency: write grant->ack = 1 cycle. Read grant->ack = 2 + memory latency cycles.
//  Back-to-back: grant possible the cycle after ack; write throughput 1 per 2 cycles.
//  s_read_valid outside ISSUE/RD_WAIT is ignored. gnt is never asserted outside IDLE.
//  Non-owner rdata/ack unaffected. s_* outputs are 0 in IDLE (address/data/mask also zeroed).
//  Mask/data passed unmodified; no address decode (Top gates dmem write_enable).
// CONFIGURATION
//  DMEM_ARB_TIMEOUT_EN defined: 8-bit wait counter cleared on RD_WAIT entry.
//   Counter reaching TIMEOUT with no s_read_valid -> rdata=32'hDEAD_BEEF, ack+err pulse, next=IDLE.
//  Undefined: RD_WAIT waits indefinitely. Err ports remain and are tied 0.
// STRUCTURE
//  dmem_arb_pkg: state_t enum {IDLE, ISSUE, RD_WAIT}, owner_t (1 bit), localparam TIMEOUT_DATA = 32'hDEAD_BEEF.
//  Sub-module rr_pick2: req[1:0], last_owner -> gnt_onehot[1:0]; purely combinational.
// TESTING
//  Write from m0 only (addr 0x9000_0010, data 0xA5A5_0001, mask 4'hF) -> gnt same cycle; next cycle
//   s_write_enable=1 with those values and m0_ack=1.
//  Reads from m0 and m1 in the same cycle after reset -> m0 granted first, m1 granted the cycle after m0_ack.
//   Repeat -> alternation holds.
//  Read m1 from a memory with 1-cycle latency returning 0x1234_5678 -> m1_ack at grant+3, m1_rdata=0x1234_5678.
//   m0_rdata unchanged.
//  Zero-latency memory (read_valid in ISSUE) -> ack at grant+2. Stray s_read_valid in IDLE -> no ack.
//  Assert rst in RD_WAIT, then release; a late s_read_valid arrives -> all outputs 0, no ack; next req serviced normally.
//  DMEM_ARB_TIMEOUT_EN, TIMEOUT=16, memory never responds -> ack+err at RD_WAIT entry+16, rdata=0xDEAD_BEEF, busy drops.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_t;

  // Which requester owns the current transaction.
  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_t;

  // Read data returned when a read is abandoned after the wait limit.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Width of the read-wait counter.
  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins; with both requesting,
// the one that did not own the previous transaction wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  owner_t     last_owner_i,
  output logic [1:0] gnt_onehot_o
);

  // Pure combinational selection of a single winner.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    gnt_onehot_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_onehot_o = 2'b01;
      2'b10:   gnt_onehot_o = 2'b10;
      2'b11:   gnt_onehot_o = (last_owner_i == OWNER_M1) ? 2'b01 : 2'b10;
      default: gnt_onehot_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one DMemory port between the core load/store path (m0) and the
// UART loader / debug writer (m1). One transaction in flight at a time,
// round-robin between requesters, memory strobes driven from registers.
// Optional feature macro: DMEM_ARB_TIMEOUT_EN (read-wait timeout with err pulse).
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_gnt,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,

  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_gnt,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,

  output logic [ADDR_W-1:0]   s_address,
  output logic [DATA_W-1:0]   s_write_data,
  output logic [DATA_W/8-1:0] s_write_mask,
  output logic                s_write_enable,
  output logic                s_read_enable,
  input  logic [DATA_W-1:0]   s_read_data,
  input  logic                s_read_valid,

  output logic                busy
);

  localparam int MASK_W = DATA_W / 8;

  state_t                   state_q;
  owner_t                   owner_q;
  owner_t                   last_owner_q;
  logic                     we_q;
  logic                     rd_done_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [MASK_W-1:0]        mask_q;
  logic                     s_we_q;
  logic                     s_re_q;
  logic [1:0]               ack_q;
  logic [1:0][DATA_W-1:0]   rdata_q;
`ifdef DMEM_ARB_TIMEOUT_EN
  logic [1:0]               err_q;
  logic [WAIT_CNT_W-1:0]    wait_cnt_q;
`endif

  logic [1:0]               pick;
  logic [1:0]               gnt_vec;
  owner_t                   gnt_owner;
  logic                     sel_we;
  logic [ADDR_W-1:0]        sel_addr;
  logic [DATA_W-1:0]        sel_wdata;
  logic [MASK_W-1:0]        sel_mask;

  rr_pick2 u_pick (
    .req_i        ({m1_req, m0_req}),
    .last_owner_i (last_owner_q),
    .gnt_onehot_o (pick)
  );

  // Grants exist only while idle; payload comes from the winning requester.
  always_comb begin
    gnt_vec   = (state_q == IDLE) ? pick : 2'b00;
    gnt_owner = gnt_vec[1] ? OWNER_M1 : OWNER_M0;
    sel_we    = gnt_vec[1] ? m1_we    : m0_we;
    sel_addr  = gnt_vec[1] ? m1_addr  : m0_addr;
    sel_wdata = gnt_vec[1] ? m1_wdata : m0_wdata;
    sel_mask  = gnt_vec[1] ? m1_wmask : m0_wmask;
  end

  // Transaction sequencer: grant capture, memory issue, read completion.
  // The latched address/data/mask double as the memory-side outputs and are
  // zeroed whenever the sequencer returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_M0;
      last_owner_q <= OWNER_M1;
      we_q         <= 1'b0;
      rd_done_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      s_we_q       <= 1'b0;
      s_re_q       <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
`ifdef DMEM_ARB_TIMEOUT_EN
      err_q        <= '0;
      wait_cnt_q   <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ack_q  <= '0;
      s_we_q <= 1'b0;
      s_re_q <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      err_q  <= '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (|gnt_vec) begin
            owner_q      <= gnt_owner;
            last_owner_q <= gnt_owner;
            we_q         <= sel_we;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            mask_q       <= sel_mask;
            s_we_q       <= sel_we;
            s_re_q       <= ~sel_we;
            rd_done_q    <= 1'b0;
            // A write completes in the issue cycle, so its ack is armed now.
            if (sel_we) ack_q[gnt_owner] <= 1'b1;
            state_q      <= ISSUE;
          end
        end

        ISSUE: begin
          if (we_q) begin
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            state_q <= IDLE;
          end else begin
            state_q <= RD_WAIT;
`ifdef DMEM_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
            // Zero-latency memory: data is already here in the issue cycle.
            if (s_read_valid) begin
              rdata_q[owner_q] <= s_read_data;
              ack_q[owner_q]   <= 1'b1;
              rd_done_q        <= 1'b1;
            end
          end
        end

        RD_WAIT: begin
          if (rd_done_q) begin
            // Ack is visible this cycle; release the port.
            rd_done_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            state_q   <= IDLE;
          end else if (s_read_valid) begin
            rdata_q[owner_q] <= s_read_data;
            ack_q[owner_q]   <= 1'b1;
            rd_done_q        <= 1'b1;
          end
`ifdef DMEM_ARB_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_CNT_W'(TIMEOUT - 1)) begin
            // Give up on the memory: complete with a marker value and flag it.
            rdata_q[owner_q] <= DATA_W'(TIMEOUT_DATA);
            ack_q[owner_q]   <= 1'b1;
            err_q[owner_q]   <= 1'b1;
            rd_done_q        <= 1'b1;
            wait_cnt_q       <= wait_cnt_q + 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign m0_gnt         = gnt_vec[0];
  assign m1_gnt         = gnt_vec[1];
  assign m0_ack         = ack_q[0];
  assign m1_ack         = ack_q[1];
  assign m0_rdata       = rdata_q[0];
  assign m1_rdata       = rdata_q[1];
`ifdef DMEM_ARB_TIMEOUT_EN
  assign m0_err         = err_q[0];
  assign m1_err         = err_q[1];
`else
  assign m0_err         = 1'b0;
  assign m1_err         = 1'b0;
`endif
  assign s_address      = addr_q;
  assign s_write_data   = wdata_q;
  assign s_write_mask   = mask_q;
  assign s_write_enable = s_we_q;
  assign s_read_enable  = s_re_q;
  assign busy           = (state_q != IDLE);

endmodule
